tnoc_route_selector: RTL and testbench

Input stage that sits directly upstream of the flit demux in a router port. Buffers incoming flits in a two-entry skid buffer and computes the one-hot output-port select from each packet's head flit using XY routing. Holds that select per virtual channel until the packet's tail flit leaves. Presents the buffered flit stream plus the select to the demux, which fans it out to the five router outputs.

---
 rtl/tnoc_route_selector_pkg.sv | 64 ++++++
 rtl/tnoc_flit_if.sv | 29 ++
 rtl/tnoc_route_selector_skid_buffer.sv | 54 +++++
 rtl/tnoc_route_selector.sv | 104 ++++++++++
 tb/tb_tnoc_route_selector.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tnoc_route_selector_pkg.sv
// Shared NoC types for the route selector: configuration, flit layout, port
// indices and the XY route function.
package tnoc_route_selector_pkg;

    localparam int TNOC_ID_X_WIDTH = 2;
    localparam int TNOC_ID_Y_WIDTH = 2;
    localparam int TNOC_DATA_WIDTH = 16;
    localparam int TNOC_VIRTUAL_CHANNELS = 2;
    localparam int TNOC_PORTS = 5;

    typedef struct packed {
        int id_x_width;
        int id_y_width;
        int data_width;
        int virtual_channels;
    } tnoc_config_t;

    localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{
        id_x_width:       TNOC_ID_X_WIDTH,
        id_y_width:       TNOC_ID_Y_WIDTH,
        data_width:       TNOC_DATA_WIDTH,
        virtual_channels: TNOC_VIRTUAL_CHANNELS
    };

    typedef struct packed {
        logic                       head;
        logic                       tail;
        logic [TNOC_ID_X_WIDTH-1:0] dst_x;
        logic [TNOC_ID_Y_WIDTH-1:0] dst_y;
        logic [TNOC_DATA_WIDTH-1:0] data;
    } tnoc_flit_t;

    typedef enum logic [2:0] {
        PORT_X_PLUS  = 3'd0,
        PORT_X_MINUS = 3'd1,
        PORT_Y_PLUS  = 3'd2,
        PORT_Y_MINUS = 3'd3,
        PORT_LOCAL   = 3'd4
    } tnoc_port_e;

    // Dimension-ordered routing: resolve x first, then y, else deliver locally.
    function automatic logic [TNOC_PORTS-1:0] tnoc_route(
        input logic [TNOC_ID_X_WIDTH-1:0] dst_x,
        input logic [TNOC_ID_Y_WIDTH-1:0] dst_y,
        input logic [TNOC_ID_X_WIDTH-1:0] x,
        input logic [TNOC_ID_Y_WIDTH-1:0] y
    );
        logic [TNOC_PORTS-1:0] sel;
        sel = '0;
        if (dst_x > x) begin
            sel[PORT_X_PLUS] = 1'b1;
        end else if (dst_x < x) begin
            sel[PORT_X_MINUS] = 1'b1;
        end else if (dst_y > y) begin
            sel[PORT_Y_PLUS] = 1'b1;
        end else if (dst_y < y) begin
            sel[PORT_Y_MINUS] = 1'b1;
        end else begin
            sel[PORT_LOCAL] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/tnoc_flit_if.sv
// Per-virtual-channel flit stream with a shared flit field.
interface tnoc_flit_if #(
    parameter int CHANNELS = 2
);
    import tnoc_route_selector_pkg::*;

    // valid[c]/ready[c]: a flit on channel c transfers on a clock edge where
    // both are high; valid must not depend on ready, and at most one valid bit
    // is high per cycle because the flit field is shared.
    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] vc_available;
    tnoc_flit_t          flit;

    modport initiator (
        output valid,
        output flit,
        input  ready,
        input  vc_available
    );

    modport target (
        input  valid,
        input  flit,
        output ready,
        output vc_available
    );

endinterface

// File: rtl/tnoc_route_selector_skid_buffer.sv
// Two-entry FIFO holding a flit and its virtual-channel index, entry 0 is head.
module tnoc_route_selector_skid_buffer
    import tnoc_route_selector_pkg::*;
#(
    parameter int CH_W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  tnoc_flit_t      push_flit,
    input  logic [CH_W-1:0] push_ch,
    input  logic            pop,
    output tnoc_flit_t      head_flit,
    output logic [CH_W-1:0] head_ch,
    output logic [1:0]      count
);

    tnoc_flit_t      flit_q [2];
    logic [CH_W-1:0] ch_q   [2];
    logic [1:0]      count_q;
    logic            do_push;
    logic            do_pop;
    logic            wr_idx;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && (count_q != 2'd2);
    // The write lands behind whatever remains after this cycle's pop.
    assign wr_idx  = (count_q == 2'd1) && !do_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                flit_q[i] <= '0;
                ch_q[i]   <= '0;
            end
        end else begin
            if (do_pop) begin
                flit_q[0] <= flit_q[1];
                ch_q[0]   <= ch_q[1];
            end
            if (do_push) begin
                flit_q[wr_idx] <= push_flit;
                ch_q[wr_idx]   <= push_ch;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_flit = flit_q[0];
    assign head_ch   = ch_q[0];
    assign count     = count_q;

endmodule

// File: rtl/tnoc_route_selector.sv
// Router input stage: skid-buffers flits and attaches a per-VC locked XY route.
// Build option: TNOC_ROUTE_SELECTOR_ERROR_CHECK_EN drops out-of-order flits.
module tnoc_route_selector
    import tnoc_route_selector_pkg::*;
#(
    parameter tnoc_config_t               CONFIG   = TNOC_DEFAULT_CONFIG,
    parameter int                         CHANNELS = CONFIG.virtual_channels,
    parameter logic [TNOC_ID_X_WIDTH-1:0] X        = '0,
    parameter logic [TNOC_ID_Y_WIDTH-1:0] Y        = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tnoc_flit_if.target           flit_in_if,
    tnoc_flit_if.initiator        flit_out_if,
    output logic [TNOC_PORTS-1:0] o_select,
    output logic                  o_protocol_error
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [1:0]            count;
    logic                  buf_valid;
    tnoc_flit_t            head_flit;
    logic [CH_W-1:0]       head_ch;
    logic                  push;
    logic [CH_W-1:0]       push_ch;
    logic                  pop;
    logic                  drop;
    logic                  fwd_pop;
    logic                  head_locked;
    logic [TNOC_PORTS-1:0] head_route;
    logic [CHANNELS-1:0]   lock_q;
    logic [TNOC_PORTS-1:0] sel_q [CHANNELS];

    assign flit_in_if.ready        = {CHANNELS{count != 2'd2}};
    assign flit_in_if.vc_available = flit_out_if.vc_available;
    assign push                    = |(flit_in_if.valid & flit_in_if.ready);

    always_comb begin
        push_ch = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (flit_in_if.valid[c]) begin
                push_ch = CH_W'(c);
            end
        end
    end

    tnoc_route_selector_skid_buffer #(
        .CH_W (CH_W)
    ) u_skid_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_flit (flit_in_if.flit),
        .push_ch   (push_ch),
        .pop       (pop),
        .head_flit (head_flit),
        .head_ch   (head_ch),
        .count     (count)
    );

    assign buf_valid   = (count != 2'd0);
    assign head_locked = lock_q[head_ch];
    assign head_route  = tnoc_route(head_flit.dst_x, head_flit.dst_y, X, Y);

`ifdef TNOC_ROUTE_SELECTOR_ERROR_CHECK_EN
    // A non-head flit with no open packet on its channel has no route to follow.
    assign drop = buf_valid && !head_flit.head && !head_locked;
`else
    assign drop = 1'b0;
`endif

    assign o_protocol_error = drop;
    assign flit_out_if.flit = head_flit;

    always_comb begin
        flit_out_if.valid = '0;
        if (buf_valid && !drop) begin
            flit_out_if.valid[head_ch] = 1'b1;
        end
    end

    assign pop      = buf_valid && (drop || flit_out_if.ready[head_ch]);
    assign fwd_pop  = pop && !drop;
    assign o_select = buf_valid ? (head_locked ? sel_q[head_ch] : head_route) : '0;

    // A head arriving on an already-locked channel keeps the existing route.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sel_q[c] <= '0;
            end
        end else if (fwd_pop) begin
            if (head_flit.tail) begin
                lock_q[head_ch] <= 1'b0;
            end else if (head_flit.head && !head_locked) begin
                lock_q[head_ch] <= 1'b1;
                sel_q[head_ch]  <= head_route;
            end
        end
    end

endmodule

// File: tb/tb_tnoc_route_selector.sv
// Randomized and directed checks of tnoc_route_selector against a packet-level model.
module tb_tnoc_route_selector;
    import tnoc_route_selector_pkg::*;

    localparam int CHANNELS = 2;
    localparam int FW       = $bits(tnoc_flit_t);
    localparam int EW       = 5 + 1 + FW;
    localparam int RX       = 1;
    localparam int RY       = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tnoc_flit_if #(.CHANNELS(CHANNELS)) in_if ();
    tnoc_flit_if #(.CHANNELS(CHANNELS)) out_if ();
    logic [4:0] o_select;
    logic       o_protocol_error;

    tnoc_route_selector #(
        .X (2'd1),
        .Y (2'd1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flit_in_if       (in_if),
        .flit_out_if      (out_if),
        .o_select         (o_select),
        .o_protocol_error (o_protocol_error)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [4:0] pkt_sel [CHANNELS];
    int         rem [CHANNELS];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_route(input int dx, input int dy);
        if (dx > RX) return 5'b00001;
        if (dx < RX) return 5'b00010;
        if (dy > RY) return 5'b00100;
        if (dy < RY) return 5'b01000;
        return 5'b10000;
    endfunction

    function automatic tnoc_flit_t mk(input bit h, input bit t, input int dx, input int dy);
        tnoc_flit_t f;
        f.head  = h;
        f.tail  = t;
        f.dst_x = 2'(dx);
        f.dst_y = 2'(dy);
        f.data  = 16'($urandom);
        return f;
    endfunction

    // One clock: drive at negedge, check outputs, then retire/queue what the
    // coming posedge will transfer.
    task automatic step(input bit v, input int ch, input tnoc_flit_t f, input bit ordy,
                        output bit acc);
        int sz;
        logic [EW-1:0] e;
        @(negedge clk);
        in_if.valid = '0;
        if (v) in_if.valid[ch] = 1'b1;
        in_if.flit = f;
        out_if.ready = ordy ? 2'b11 : 2'b00;
        out_if.vc_available = 2'($urandom_range(0, 3));
        #1;
        sz = exp_q.size();
        check("ready", 32'(in_if.ready), (sz < 2) ? 32'h3 : 32'h0);
        check("vc_avail", 32'(in_if.vc_available), 32'(out_if.vc_available));
        check("perr", 32'(o_protocol_error), 32'h0);
        if (sz == 0) begin
            check("valid_idle", 32'(out_if.valid), 32'h0);
            check("sel_idle", 32'(o_select), 32'h0);
        end else begin
            e = exp_q[0];
            check("valid", 32'(out_if.valid), 32'(1) << e[FW]);
            check("flit", 32'(out_if.flit), 32'(e[FW-1:0]));
            check("select", 32'(o_select), 32'(e[EW-1 -: 5]));
            if (ordy) void'(exp_q.pop_front());
        end
        acc = v && (sz < 2);
        if (acc) begin
            if (f.head) pkt_sel[ch] = ref_route(int'(f.dst_x), int'(f.dst_y));
            exp_q.push_back({pkt_sel[ch], 1'(ch), f});
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        in_if.valid = '0;
        out_if.ready = 2'b11;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rem = '{0, 0};
        #1;
        check("rst_valid", 32'(out_if.valid), 32'h0);
        check("rst_select", 32'(o_select), 32'h0);
        check("rst_ready", 32'(in_if.ready), 32'h3);
        check("rst_perr", 32'(o_protocol_error), 32'h0);
    endtask

    initial begin
        bit acc;
        int k;
        int ch;
        int len;
        bit v;
        tnoc_flit_t f;
        tnoc_flit_t bf;
        in_if.valid = '0;
        in_if.flit = '0;
        out_if.ready = 2'b11;
        out_if.vc_available = '0;
        pkt_sel = '{5'd0, 5'd0};
        do_reset(2);

        // single-flit packet to (2,1) on ch0, then idle
        step(1, 0, mk(1, 1, 2, 1), 1, acc);
        repeat (2) step(0, 0, '0, 1, acc);

        // 4-flit packet to (1,0) on ch1; body destinations are noise
        for (int i = 0; i < 4; i++)
            step(1, 1, mk(i == 0, i == 3, (i == 0) ? 1 : $urandom_range(0, 3),
                          (i == 0) ? 0 : $urandom_range(0, 3)), 1, acc);
        // lock on ch1 must be gone: next packet routes locally
        step(1, 1, mk(1, 1, 1, 1), 1, acc);
        repeat (2) step(0, 0, '0, 1, acc);

        // interleaved packets: ch0 to (0,1), ch1 to (1,1)
        for (int i = 0; i < 6; i++) begin
            ch = i % 2;
            k = i / 2;
            step(1, ch, mk(k == 0, k == 2, (k == 0) ? ch : $urandom_range(0, 3),
                           (k == 0) ? 1 : $urandom_range(0, 3)), 1, acc);
        end
        repeat (2) step(0, 0, '0, 1, acc);

        // downstream stalls for 5 cycles during a 6-flit burst to (3,0)
        k = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (k < 6)
                step(1, 0, mk(k == 0, k == 5, (k == 0) ? 3 : $urandom_range(0, 3),
                              (k == 0) ? 0 : $urandom_range(0, 3)), cyc >= 5, acc);
            else
                step(0, 0, '0, 1, acc);
            if (acc) k++;
        end

        // body flit on unlocked ch0
        bf = mk(0, 0, 0, 2);
        @(negedge clk);
        in_if.valid = 2'b01;
        in_if.flit = bf;
        out_if.ready = 2'b11;
        #1;
        check("err_ready", 32'(in_if.ready), 32'h3);
        @(negedge clk);
        in_if.valid = '0;
        #1;
`ifdef TNOC_ROUTE_SELECTOR_ERROR_CHECK_EN
        check("err_valid", 32'(out_if.valid), 32'h0);
        check("err_pulse", 32'(o_protocol_error), 32'h1);
`else
        check("err_valid", 32'(out_if.valid), 32'h1);
        check("err_flit", 32'(out_if.flit), 32'(bf));
        check("err_select", 32'(o_select), 32'(ref_route(0, 2)));
        check("err_pulse", 32'(o_protocol_error), 32'h0);
`endif
        @(negedge clk);
        #1;
        check("err_after_perr", 32'(o_protocol_error), 32'h0);
        check("err_after_valid", 32'(out_if.valid), 32'h0);

        // reset with two entries buffered mid-packet, then a fresh packet on ch1
        step(1, 1, mk(1, 0, 0, 0), 0, acc);
        step(1, 1, mk(0, 0, 3, 3), 0, acc);
        step(1, 1, mk(0, 0, 3, 3), 0, acc);
        do_reset(1);
        step(1, 1, mk(1, 1, 2, 2), 1, acc);
        step(0, 0, '0, 1, acc);

        // randomized well-formed traffic on both channels
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            ch = $urandom_range(0, 1);
            if (rem[ch] == 0) begin
                len = $urandom_range(1, 4);
                f = mk(1, len == 1, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                len = 0;
                f = mk(0, rem[ch] == 1, $urandom_range(0, 3), $urandom_range(0, 3));
            end
            step(v, ch, f, $urandom_range(0, 3) != 0, acc);
            if (acc) rem[ch] = (len != 0) ? len - 1 : rem[ch] - 1;
        end

        repeat (4) step(0, 0, '0, 1, acc);
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
